// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD text sequencer and its character buffer.
package lcd_pkg;

  // HD44780 "Set DDRAM address" opcode; the low 7 bits carry the address.
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

  // Register-select encodings presented to the byte-level driver.
  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  // Fill value for the character buffer after reset (ASCII space).
  localparam logic [7:0] DEFAULT_BLANK_CHAR = 8'h20;

  // Sequencer states: waiting for a dirty line, presenting the address
  // command, streaming the line's characters.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } seq_state_t;

  // Build the Set-DDRAM command byte for a line base address.
  function automatic logic [7:0] ddram_cmd(input logic [7:0] base_addr);
    return CMD_SET_DDRAM | base_addr;
  endfunction

endpackage

// File: rtl/lcd_char_buffer.sv
// Two-line character store: one synchronous write port, one combinational
// read port. Every cell is filled with the blank character on reset.
module lcd_char_buffer
  import lcd_pkg::*;
#(
  parameter int         COLS       = 16,
  parameter logic [7:0] BLANK_CHAR = DEFAULT_BLANK_CHAR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     wr_line,
  input  logic [$clog2(COLS)-1:0]  wr_col,
  input  logic [7:0]               wr_data,
  input  logic                     rd_line,
  input  logic [$clog2(COLS)-1:0]  rd_col,
  output logic [7:0]               rd_data
);

  logic [7:0] mem_r [0:1][0:COLS-1];

  // Character array: blank fill on reset, single-cell update on write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int l = 0; l < 2; l++) begin
        for (int c = 0; c < COLS; c++) begin
          mem_r[l][c] <= BLANK_CHAR;
        end
      end
    end else if (wr_en) begin
      mem_r[wr_line][wr_col] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_line][rd_col];

endmodule

// File: rtl/lcd_text_sequencer.sv
// Streams changed display lines to the HD44780 byte driver: one Set-DDRAM
// command followed by COLS character bytes per line, over valid/ready.
module lcd_text_sequencer
  import lcd_pkg::*;
#(
  parameter int         COLS       = 16,
  parameter logic [7:0] LINE0_ADDR = 8'h00,
  parameter logic [7:0] LINE1_ADDR = 8'h40,
  parameter logic [7:0] BLANK_CHAR = DEFAULT_BLANK_CHAR
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [$clog2(COLS):0]     wr_addr,
  input  logic [7:0]                wr_data,
  input  logic                      refresh,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_rs,
  output logic [7:0]                out_data,
  output logic                      busy
);

  localparam int COL_W = $clog2(COLS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  seq_state_t       state_r, state_s;
  logic             line_r, line_s;
  logic [COL_W-1:0] col_r, col_s;
  logic [1:0]       dirty_r, dirty_s;
  logic [1:0]       clear_s, set_s;
  logic             out_valid_r, out_valid_s;
  logic             out_rs_r, out_rs_s;
  logic [7:0]       out_data_r, out_data_s;
  logic             busy_r, busy_s;
  logic             xfer_s;
  logic [COL_W-1:0] rd_col_s;
  logic [7:0]       rd_data_s;

  lcd_char_buffer #(
    .COLS       (COLS),
    .BLANK_CHAR (BLANK_CHAR)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_line (wr_addr[COL_W]),
    .wr_col  (wr_addr[COL_W-1:0]),
    .wr_data (wr_data),
    .rd_line (line_r),
    .rd_col  (rd_col_s),
    .rd_data (rd_data_s)
  );

  assign xfer_s = out_valid_r & out_ready;

  // Read address: column 0 while the command is pending, otherwise the
  // column after the one currently presented (wraps harmlessly on the last).
  always_comb begin
    rd_col_s = '0;
    if (state_r == DATA) begin
      rd_col_s = col_r + COL_W'(1);
    end else begin
      rd_col_s = '0;
    end
  end

  // Dirty set requests from host writes and refresh pulses.
  always_comb begin
    set_s = 2'b00;
    if (refresh) begin
      set_s = 2'b11;
    end else begin
      set_s = 2'b00;
    end
    if (wr_en) begin
      set_s[wr_addr[COL_W]] = 1'b1;
    end else begin
      set_s = set_s;
    end
    // A set arriving in the same cycle as a clear must win.
    dirty_s = (dirty_r & ~clear_s) | set_s;
  end

  // Next-state and output-register logic; outputs hold while stalled.
  always_comb begin
    state_s     = state_r;
    line_s      = line_r;
    col_s       = col_r;
    clear_s     = 2'b00;
    out_valid_s = out_valid_r;
    out_rs_s    = out_rs_r;
    out_data_s  = out_data_r;

    case (state_r)
      IDLE: begin
        out_valid_s = 1'b0;
        if (dirty_r[0]) begin
          line_s      = 1'b0;
          clear_s     = 2'b01;
          out_rs_s    = RS_CMD;
          out_data_s  = ddram_cmd(LINE0_ADDR);
          out_valid_s = 1'b1;
          state_s     = CMD;
        end else if (dirty_r[1]) begin
          line_s      = 1'b1;
          clear_s     = 2'b10;
          out_rs_s    = RS_CMD;
          out_data_s  = ddram_cmd(LINE1_ADDR);
          out_valid_s = 1'b1;
          state_s     = CMD;
        end else begin
          state_s = IDLE;
        end
      end

      CMD: begin
        if (xfer_s) begin
          out_rs_s   = RS_DATA;
          out_data_s = rd_data_s;
          col_s      = '0;
          state_s    = DATA;
        end else begin
          state_s = CMD;
        end
      end

      DATA: begin
        if (xfer_s) begin
          if (col_r == LAST_COL) begin
            out_valid_s = 1'b0;
            state_s     = IDLE;
          end else begin
            col_s      = col_r + COL_W'(1);
            out_data_s = rd_data_s;
          end
        end else begin
          state_s = DATA;
        end
      end

      default: begin
        out_valid_s = 1'b0;
        state_s     = IDLE;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  // State, dirty flags and driver-facing output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      line_r      <= 1'b0;
      col_r       <= '0;
      dirty_r     <= 2'b11;
      out_valid_r <= 1'b0;
      out_rs_r    <= RS_CMD;
      out_data_r  <= 8'h00;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      line_r      <= line_s;
      col_r       <= col_s;
      dirty_r     <= dirty_s;
      out_valid_r <= out_valid_s;
      out_rs_r    <= out_rs_s;
      out_data_r  <= out_data_s;
      busy_r      <= busy_s;
    end
  end

  assign out_valid = out_valid_r;
  assign out_rs    = out_rs_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Scoreboard bench: stimulus pushes expected {rs,data} bytes derived from a
// line-level model of the display buffer; a monitor pops on every transfer.
module tb_lcd_text_sequencer;
  import lcd_pkg::*;

  localparam int         COLS = 16;
  localparam int         AW   = $clog2(COLS) + 1;
  localparam logic [7:0] L0   = 8'h00;
  localparam logic [7:0] L1   = 8'h40;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = 8'h00;
  logic          refresh = 1'b0;
  logic          out_valid, out_rs, busy, out_ready;
  logic [7:0]    out_data;
  logic          man_ready = 1'b0;
  logic          rnd_ready = 1'b0;
  int            ready_mode = 0;

  assign out_ready = (ready_mode != 0) ? rnd_ready : man_ready;

  always #5 clk = ~clk;

  lcd_text_sequencer #(
    .COLS(COLS), .LINE0_ADDR(L0), .LINE1_ADDR(L1), .BLANK_CHAR(8'h20)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .refresh(refresh), .out_valid(out_valid), .out_ready(out_ready),
    .out_rs(out_rs), .out_data(out_data), .busy(busy)
  );

  int         checks = 0;
  int         errors = 0;
  int         xfer_count = 0;
  logic [8:0] exp_q[$];
  logic [7:0] mdl[2][COLS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Random ready, changed well away from the sampling point.
  always @(negedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: samples just before each rising edge.
  logic       pv = 1'b0, pr = 1'b0, prs = 1'b0;
  logic [7:0] pd = 8'h00;
  always @(negedge clk) begin
    #4;
    if (!rst) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) check("stall_hold", {out_valid, out_rs, out_data}, {1'b1, prs, pd});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte actual=%0h required=none", {out_rs, out_data});
        end else begin
          check("byte", {out_rs, out_data}, exp_q.pop_front());
        end
        xfer_count++;
      end
      pv = out_valid; pr = out_ready; prs = out_rs; pd = out_data;
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic push_line(input int l);
    exp_q.push_back({RS_CMD, CMD_SET_DDRAM | ((l == 0) ? L0 : L1)});
    for (int c = 0; c < COLS; c++) exp_q.push_back({RS_DATA, mdl[l][c]});
  endtask

  task automatic blank_model();
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < COLS; c++) mdl[l][c] = 8'h20;
  endtask

  task automatic do_write(input int l, input int c, input logic [7:0] d);
    wr_en = 1'b1;
    wr_addr = AW'(l * COLS + c);
    wr_data = d;
    mdl[l][c] = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && !out_valid && !busy) && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL drain_%s actual=timeout(queue %0d) required=idle", name, exp_q.size());
    end
  endtask

  task automatic wait_count(input int target, input string name);
    int n = 0;
    while (xfer_count < target && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL wait_%s actual=%0d required=%0d", name, xfer_count, target);
    end
  endtask

  initial begin
    int base;
    blank_model();

    // Test 1: reset values, then automatic blanking of both lines.
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_rs", out_rs, 0);
    check("rst_data", out_data, 8'h00);
    check("rst_busy", busy, 0);
    tick();
    man_ready = 1'b1;
    push_line(0);
    push_line(1);
    rst = 1'b1;
    drain("t1");

    // Test 2: single write, latency and line-0-only refresh.
    tick();
    wr_en = 1'b1; wr_addr = AW'(0); wr_data = 8'h48; mdl[0][0] = 8'h48;
    push_line(0);
    tick();
    wr_en = 1'b0;
    check("t2_valid_edge_n", out_valid, 0);
    tick();
    check("t2_valid_edge_n1", out_valid, 1);
    check("t2_cmd", {out_rs, out_data}, {1'b0, 8'h80});
    drain("t2");

    // Test 3: seven-cycle stall on the third data byte.
    base = xfer_count;
    do_write(0, 10, 8'h5A);
    push_line(0);
    wait_count(base + 3, "t3");
    man_ready = 1'b0;
    repeat (7) tick();
    check("t3_held", {out_valid, out_rs, out_data}, {1'b1, 1'b1, mdl[0][2]});
    man_ready = 1'b1;
    drain("t3");

    // Test 4: write to an already-sent column forces a second refresh.
    base = xfer_count;
    do_write(0, 7, 8'h37);
    push_line(0);
    wait_count(base + 4, "t4");
    tick();
    do_write(0, 2, 8'h41);
    push_line(0);
    drain("t4");

    // Test 5: refresh with both lines dirty; line 0 first, exactly two lines.
    man_ready = 1'b0;
    refresh = 1'b1;
    do_write(1, 3, 8'h62);
    refresh = 1'b0;
    push_line(0);
    push_line(1);
    repeat (3) tick();
    man_ready = 1'b1;
    drain("t5");

    // Random bursts while the driver is stalled, then random-ready drain.
    for (int it = 0; it < 12; it++) begin
      int  len, chosen, l, c;
      bit  s0, s1;
      bit  dm[2];
      ready_mode = 0;
      man_ready = 1'b0;
      len = $urandom_range(1, 4);
      chosen = 0;
      dm[0] = 1'b0; dm[1] = 1'b0;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 4) == 0) begin
          refresh = 1'b1; wr_en = 1'b0; s0 = 1'b1; s1 = 1'b1;
        end else begin
          l = $urandom_range(0, 1);
          c = $urandom_range(0, COLS - 1);
          refresh = 1'b0; wr_en = 1'b1;
          wr_addr = AW'(l * COLS + c);
          wr_data = 8'($urandom);
          mdl[l][c] = wr_data;
          s0 = (l == 0); s1 = (l == 1);
        end
        if (i == 0) begin
          chosen = s0 ? 0 : 1;
          dm[0] = s0 && (chosen != 0);
          dm[1] = s1 && (chosen != 1);
        end else begin
          dm[0] = dm[0] | s0;
          dm[1] = dm[1] | s1;
        end
        tick();
      end
      wr_en = 1'b0;
      refresh = 1'b0;
      push_line(chosen);
      while (dm[0] || dm[1]) begin
        if (dm[0]) begin dm[0] = 1'b0; push_line(0); end
        else begin dm[1] = 1'b0; push_line(1); end
      end
      ready_mode = 1;
      drain("random");
      ready_mode = 0;
    end

    // Test 6: asynchronous reset while presenting column 9.
    man_ready = 1'b1;
    base = xfer_count;
    do_write(0, 1, 8'h77);
    push_line(0);
    wait_count(base + 10, "t6");
    check("t6_pre_valid", {out_valid, busy}, 2'b11);
    rst = 1'b0;
    #1;
    check("t6_abort_valid", out_valid, 0);
    check("t6_abort_busy", busy, 0);
    check("t6_abort_data", {out_rs, out_data}, 9'h000);
    exp_q.delete();
    blank_model();
    tick();
    tick();
    push_line(0);
    push_line(1);
    rst = 1'b1;
    drain("t6");

    // Quiet period: nothing further may be sent.
    repeat (40) tick();
    check("final_queue", exp_q.size(), 0);
    check("final_idle", {out_valid, busy}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
